mips_multicycle_ctrl: RTL and testbench

- Multicycle main control FSM for the MIPS core: sequences fetch/decode/execute/memory/writeback over a shared ALU and a single memory port.
- Generates the 3-bit ALUOp consumed by the ALU control decoder, plus all datapath muxes and enables.
- Handles a variable-latency memory via a req/ready handshake with timeout.
- Supports add, sub, and, or, slt (R-type), addi, andi, ori, lw, sw, beq.

---
 rtl/mips_multicycle_ctrl_if.sv | 10 +
 rtl/mips_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle controller and the shared memory.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: Moore datapath decode, memory req/ready
// handshake with timeout, and a retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [5:0]                  opcode,
    input  logic                        zero,
    mips_multicycle_ctrl_if.master      mem,
    output logic                        ir_write,
    output logic                        mdr_write,
    output logic                        pc_en,
    output logic                        pc_src,
    output logic                        alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic                        ext_zero,
    output logic [2:0]                  alu_op,
    output logic                        reg_write,
    output logic                        reg_dst,
    output logic                        mem_to_reg,
    output logic                        illegal_op,
    output logic                        mem_err,
    output logic [CNT_W-1:0]            instr_count,
    output logic [3:0]                  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_req_c, mem_we_c, i_or_d_c;
    logic timeout, retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        i_or_d_c   = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        alu_op     = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        timeout    = 1'b0;
        retire     = 1'b0;

        // Timeout only wins when ready is still low on the last allowed wait cycle.
        if (!mem.mem_ready && wait_q == WAIT_LAST &&
            (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE))
            timeout = 1'b1;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b010;
                case (opcode)
                    6'b000000:                     state_d = S_R_EXEC;
                    6'b100011, 6'b101011:          state_d = S_MEM_ADDR;
                    6'b000100:                     state_d = S_BRANCH;
                    6'b001000, 6'b001100, 6'b001101: state_d = S_I_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                state_d   = (opcode == 6'b100011) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                if (mem.mem_ready) begin
                    mdr_write = 1'b1;
                    state_d   = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                i_or_d_c  = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b100;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b011;
                pc_src    = 1'b1;
                pc_en     = zero;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_I_EXEC, S_I_WB: begin
                // The IR still holds the opcode, so alu_op/ext_zero stay stable into writeback.
                case (opcode)
                    6'b001100: begin alu_op = 3'b000; ext_zero = 1'b1; end
                    6'b001101: begin alu_op = 3'b001; ext_zero = 1'b1; end
                    default:   begin alu_op = 3'b010; ext_zero = 1'b0; end
                endcase
                if (state_q == S_I_EXEC) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_I_WB;
                end else begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (timeout) begin
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            mdr_write = 1'b0;
            mem_err   = 1'b1;
            state_d   = S_FETCH;
        end

        wait_d = wait_q;
        if (mem_req_c && !mem.mem_ready)
            wait_d = wait_q + 16'd1;
        if (timeout || (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM_READ || state_d == S_MEM_WRITE)))
            wait_d = '0;

        cnt_d = retire ? cnt_q + CNT_ONE : cnt_q;

        if (rst) begin
            mem_req_c  = 1'b0;
            mem_we_c   = 1'b0;
            i_or_d_c   = 1'b0;
            ir_write   = 1'b0;
            mdr_write  = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            ext_zero   = 1'b0;
            alu_op     = 3'b010;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_we   = mem_we_c;
    assign mem.i_or_d   = i_or_d_c;
    assign instr_count  = cnt_q;
    assign state        = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed vector bench for mips_multicycle_ctrl (TIMEOUT=4).
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        ir_write, mdr_write, pc_en, pc_src, alu_src_a, ext_zero;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg, illegal_op, mem_err;
    logic [31:0] instr_count;
    logic [3:0]  state;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem(bus),
        .ir_write(ir_write), .mdr_write(mdr_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .mem_err(mem_err),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    // Control word: req we iod _ irw mdrw pcen pcsrc _ srca srcb ext _ aluop _ rw rdst m2r _ ill err
    localparam logic [18:0] C_RST    = 19'b000_0000_0010_010_000_00;
    localparam logic [18:0] C_F_RDY  = 19'b100_1010_0010_010_000_00;
    localparam logic [18:0] C_F_NRDY = 19'b100_0000_0010_010_000_00;
    localparam logic [18:0] C_F_TO   = 19'b100_0000_0010_010_000_01;
    localparam logic [18:0] C_DEC    = 19'b000_0000_0110_010_000_00;
    localparam logic [18:0] C_DEC_IL = 19'b000_0000_0110_010_000_10;
    localparam logic [18:0] C_MADDR  = 19'b000_0000_1100_010_000_00;
    localparam logic [18:0] C_MRD_W  = 19'b101_0000_0000_000_000_00;
    localparam logic [18:0] C_MRD_R  = 19'b101_0100_0000_000_000_00;
    localparam logic [18:0] C_MWB    = 19'b000_0000_0000_000_101_00;
    localparam logic [18:0] C_MWR    = 19'b111_0000_0000_000_000_00;
    localparam logic [18:0] C_REX    = 19'b000_0000_1000_100_000_00;
    localparam logic [18:0] C_RWB    = 19'b000_0000_0000_000_110_00;
    localparam logic [18:0] C_BR1    = 19'b000_0011_1000_011_000_00;
    localparam logic [18:0] C_BR0    = 19'b000_0001_1000_011_000_00;
    localparam logic [18:0] C_IADD   = 19'b000_0000_1100_010_000_00;
    localparam logic [18:0] C_IAND   = 19'b000_0000_1101_000_000_00;
    localparam logic [18:0] C_IOR    = 19'b000_0000_1101_001_000_00;
    localparam logic [18:0] C_WADD   = 19'b000_0000_0000_010_100_00;
    localparam logic [18:0] C_WAND   = 19'b000_0000_0001_000_100_00;
    localparam logic [18:0] C_WOR    = 19'b000_0000_0001_001_100_00;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned step  = 0;

    function automatic void add(input logic r, input logic [5:0] op, input logic z,
                                input logic rdy, input logic [3:0] st,
                                input logic [18:0] ctrl, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [18:0] act;
        @(posedge clk);
        #1;
        rst = v.rst; opcode = v.op; zero = v.z; bus.mem_ready = v.rdy;
        @(negedge clk);
        act = {bus.mem_req, bus.mem_we, bus.i_or_d, ir_write, mdr_write, pc_en, pc_src,
               alu_src_a, alu_src_b, ext_zero, alu_op, reg_write, reg_dst, mem_to_reg,
               illegal_op, mem_err};
        check("state", {28'd0, state}, {28'd0, v.st});
        check("ctrl", {13'd0, act}, {13'd0, v.ctrl});
        check("instr_count", instr_count, v.cnt);
        step++;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);

        // reset, then R-type
        add(1, 6'b000000, 0, 1, 0, C_RST,   0);
        add(1, 6'b000000, 0, 1, 0, C_RST,   0);
        add(0, 6'b000000, 0, 1, 0, C_F_RDY, 0);
        add(0, 6'b000000, 0, 1, 1, C_DEC,   0);
        add(0, 6'b000000, 0, 1, 6, C_REX,   0);
        add(0, 6'b000000, 0, 1, 7, C_RWB,   0);
        // lw with three wait cycles
        add(0, 6'b100011, 0, 1, 0, C_F_RDY, 1);
        add(0, 6'b100011, 0, 1, 1, C_DEC,   1);
        add(0, 6'b100011, 0, 1, 2, C_MADDR, 1);
        add(0, 6'b100011, 0, 0, 3, C_MRD_W, 1);
        add(0, 6'b100011, 0, 0, 3, C_MRD_W, 1);
        add(0, 6'b100011, 0, 0, 3, C_MRD_W, 1);
        add(0, 6'b100011, 0, 1, 3, C_MRD_R, 1);
        add(0, 6'b100011, 0, 1, 4, C_MWB,   1);
        // sw
        add(0, 6'b101011, 0, 1, 0, C_F_RDY, 2);
        add(0, 6'b101011, 0, 1, 1, C_DEC,   2);
        add(0, 6'b101011, 0, 1, 2, C_MADDR, 2);
        add(0, 6'b101011, 0, 1, 5, C_MWR,   2);
        // beq taken / not taken
        add(0, 6'b000100, 1, 1, 0, C_F_RDY, 3);
        add(0, 6'b000100, 1, 1, 1, C_DEC,   3);
        add(0, 6'b000100, 1, 1, 8, C_BR1,   3);
        add(0, 6'b000100, 0, 1, 0, C_F_RDY, 4);
        add(0, 6'b000100, 0, 1, 1, C_DEC,   4);
        add(0, 6'b000100, 0, 1, 8, C_BR0,   4);
        // addi, andi, ori
        add(0, 6'b001000, 0, 1, 0,  C_F_RDY, 5);
        add(0, 6'b001000, 0, 1, 1,  C_DEC,   5);
        add(0, 6'b001000, 0, 1, 9,  C_IADD,  5);
        add(0, 6'b001000, 0, 1, 10, C_WADD,  5);
        add(0, 6'b001100, 0, 1, 0,  C_F_RDY, 6);
        add(0, 6'b001100, 0, 1, 1,  C_DEC,   6);
        add(0, 6'b001100, 0, 1, 9,  C_IAND,  6);
        add(0, 6'b001100, 0, 1, 10, C_WAND,  6);
        add(0, 6'b001101, 0, 1, 0,  C_F_RDY, 7);
        add(0, 6'b001101, 0, 1, 1,  C_DEC,   7);
        add(0, 6'b001101, 0, 1, 9,  C_IOR,   7);
        add(0, 6'b001101, 0, 1, 10, C_WOR,   7);
        // illegal opcode: pulse in DECODE, back to FETCH, not retired
        add(0, 6'b111111, 0, 1, 0, C_F_RDY,  8);
        add(0, 6'b111111, 0, 1, 1, C_DEC_IL, 8);
        add(0, 6'b000000, 0, 1, 0, C_F_RDY,  8);

        foreach (vecs[i]) apply(vecs[i]);

        // Fetch timeout with TIMEOUT=4: error on the 4th waiting cycle, then re-fetch
        vecs.delete();
        add(0, 6'b000000, 0, 1, 1, C_DEC, 8);
        add(0, 6'b000000, 0, 1, 6, C_REX, 8);
        add(0, 6'b000000, 0, 1, 7, C_RWB, 8);
        for (int k = 1; k <= 6; k++)
            add(0, 6'b000000, 0, 0, 0, (k == 4) ? C_F_TO : C_F_NRDY, 9);
        // Reset in the middle of a store: write strobe drops, no retire, count cleared
        add(0, 6'b101011, 0, 1, 0, C_F_RDY, 9);
        add(0, 6'b101011, 0, 1, 1, C_DEC,   9);
        add(0, 6'b101011, 0, 1, 2, C_MADDR, 9);
        add(0, 6'b101011, 0, 0, 5, C_MWR,   9);
        add(1, 6'b101011, 0, 0, 0, C_RST,   9);
        add(0, 6'b000000, 0, 1, 0, C_F_RDY, 0);
        foreach (vecs[i]) apply(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
